// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters.
// Holds the converter FSM state encoding, the shift iteration count and a
// helper that flags non-decimal nibbles.
package bcd_pkg;

    // Number of shift iterations for an 8-digit (32-bit) word.
    localparam int unsigned COUNTER_MAX = 32;

    // One-hot encoded states; any other encoding is treated as illegal.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_SUB3  = 3'b100
    } bcd_state_e;

    // A BCD nibble is invalid when it holds a value above 9.
    function automatic logic nibble_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_sub3_column.sv
// One BCD digit correction column for reverse double-dabble.
// A digit that reaches 8 or more after a right shift carried a 10 (shifted
// into the next lower position as 5+3), so 3 is removed to restore BCD.
// Ports:
//   din  - 4-bit digit from the working register
//   dout - corrected digit (din - 3 when din >= 8, else din)
module bcd_sub3_column (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_unsigned.sv
// Sequential reverse double-dabble converter: packed BCD in, unsigned binary out.
// Alternates one right-shift cycle with one subtract-3 correction cycle;
// a conversion occupies 63 cycles (32 shifts, 31 corrections).
// Ports:
//   clk     - clock, all state updates on rising edge
//   reset   - synchronous active-high reset
//   trigger - start request, sampled only while idle
//   bcd_in  - packed BCD input, digit 0 in [3:0]
//   idle    - 1 when no conversion is in progress
//   bin     - binary result, held between conversions
//   error   - 1 when the last converted input had a nibble above 9
module bcd_to_unsigned #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned COUNTER_MAX = bcd_pkg::COUNTER_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                idle,
    output logic [4*DIGITS-1:0] bin,
    output logic                error
);

    import bcd_pkg::*;

    localparam int unsigned W        = 4 * DIGITS;
    localparam logic [5:0]  CNT_LAST = 6'(COUNTER_MAX);

    bcd_state_e     state;
    logic [W-1:0]   bcd_sh;
    logic [W-1:0]   bin_sh;
    logic [5:0]     counter;
    logic           err_q;

    logic [W-1:0]   bcd_corr;
    logic [W-1:0]   bin_shifted;
    logic           load_err;

    // Corrected digits of the working register, used in S_SUB3.
    for (genvar i = 0; i < DIGITS; i++) begin : g_sub3
        bcd_sub3_column u_col (
            .din  (bcd_sh[4*i +: 4]),
            .dout (bcd_corr[4*i +: 4])
        );
    end

    always_comb begin
        load_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_err = load_err | nibble_invalid(bcd_in[4*i +: 4]);
        end
    end

    // Accumulator value after the current shift: LSB of the BCD register
    // enters at the top.
    assign bin_shifted = {bcd_sh[0], bin_sh[W-1:1]};

    assign idle = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bcd_sh  <= '0;
            bin_sh  <= '0;
            counter <= '0;
            err_q   <= 1'b0;
            bin     <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        bcd_sh  <= bcd_in;
                        bin_sh  <= '0;
                        counter <= 6'd1;
                        err_q   <= load_err;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_sh <= {1'b0, bcd_sh[W-1:1]};
                    bin_sh <= bin_shifted;
                    if (counter == CNT_LAST) begin
                        bin   <= bin_shifted;
                        error <= err_q;
                        state <= S_IDLE;
                    end else begin
                        counter <= counter + 6'd1;
                        state   <= S_SUB3;
                    end
                end
                S_SUB3: begin
                    bcd_sh <= bcd_corr;
                    state  <= S_SHIFT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Self-checking bench for bcd_to_unsigned using an expected-result queue.
module tb_bcd_to_unsigned;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic [31:0] bcd_in;
    logic        idle;
    logic [31:0] bin;
    logic        error;

    bcd_to_unsigned #(
        .DIGITS      (8),
        .COUNTER_MAX (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .bcd_in  (bcd_in),
        .idle    (idle),
        .bin     (bin),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic        err;
        logic        chk_bin;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic abort = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Decimal reference: weight each nibble by its power of ten.
    task automatic model(input logic [31:0] v, output logic [31:0] res, output logic err);
        logic [31:0] acc;
        logic [3:0]  nib;
        acc = 0;
        err = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            nib = v[4*i +: 4];
            if (nib > 4'd9) err = 1'b1;
            acc = acc * 10 + 32'(nib);
        end
        res = acc;
    endtask

    // Drive a one-cycle trigger once the DUT is idle and queue the expectation.
    task automatic start(input logic [31:0] v);
        int          n;
        logic [31:0] e;
        logic        er;
        n = 0;
        while (!idle && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        bcd_in  = v;
        trigger = 1'b1;
        model(v, e, er);
        sb.push_back('{val: e, err: er, chk_bin: !er});
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(idle && sb.size() == 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check_eq("done_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: count busy cycles and score each completed conversion.
    int   busy_cnt  = 0;
    logic prev_idle = 1'b1;

    always @(negedge clk) begin
        if (abort || reset) begin
            busy_cnt  = 0;
            prev_idle = 1'b1;
        end else begin
            if (!idle) begin
                busy_cnt++;
            end else if (!prev_idle) begin
                check_eq("latency", 32'(busy_cnt), 32'd63);
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk_bin) check_eq("bin", bin, e.val);
                    check_eq("error", 32'(error), 32'(e.err));
                end
                busy_cnt = 0;
            end
            prev_idle = idle;
        end
    end

    initial begin
        reset   = 1'b1;
        trigger = 1'b0;
        bcd_in  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_bin", bin, 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);

        // Zero, full-scale and a mixed pattern.
        start(32'h0000_0000); wait_done();
        start(32'h9999_9999); wait_done();
        check_eq("max_value", bin, 32'h05F5_E0FF);
        start(32'h1234_5678); wait_done();

        // Input latched at trigger; later bcd_in changes are ignored.
        start(32'h0000_0255);
        bcd_in = 32'h0000_0001;
        wait_done();
        check_eq("latched", bin, 32'h0000_00FF);

        // Invalid digit flags error; a following valid input clears it.
        start(32'h0000_001A); wait_done();
        start(32'h0000_0042); wait_done();

        // Trigger during a conversion is dropped.
        start(32'h0000_0777);
        repeat (19) @(posedge clk);
        #1;
        bcd_in  = 32'h0000_0001;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        wait_done();
        check_eq("busy_trig_bin", bin, 32'h0000_0309);
        repeat (2) @(posedge clk);
        #1 check_eq("no_queued", 32'(idle), 32'd1);

        // Reset mid-conversion aborts and clears outputs.
        start(32'h9999_9999);
        repeat (28) @(posedge clk);
        #1;
        abort  = 1'b1;
        reset  = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_idle", 32'(idle), 32'd1);
        check_eq("abort_bin", bin, 32'd0);
        check_eq("abort_error", 32'(error), 32'd0);
        abort = 1'b0;
        start(32'h0000_0010); wait_done();

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
